data_mem_ctrl: RTL and testbench

Parametrised data-memory block for the GPU datapath: a single-port-per-direction block RAM with a valid/ready load channel, byte-strobed stores, and address checking. Load requests are byte-addressed, checked for alignment and range, and read from BRAM. Results return through a 2-entry response buffer, so the core can stall the response side without losing data. It replaces the fixed 64-bit × 1024 word memory in the core's MEM stage and adds back-pressure, partial-word stores, same-cycle store-to-load forwarding and error reporting.

---
 rtl/data_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory for the GPU MEM stage: byte-strobed stores, checked loads with a
// valid/ready request channel and a 2-entry response buffer absorbing back-pressure.
module data_mem_ctrl #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_req_valid,
    output logic                  ld_req_ready,
    input  logic [ADDR_W-1:0]     ld_req_addr,
    output logic                  ld_rsp_valid,
    input  logic                  ld_rsp_ready,
    output logic [DATA_W-1:0]     ld_rsp_data,
    output logic                  ld_rsp_err,
    input  logic                  st_en,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic [DATA_W/8-1:0]   st_strb,
    output logic                  st_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    // Handshake: a load is taken on any edge where ld_req_valid && ld_req_ready;
    // a response is consumed on any edge where ld_rsp_valid && ld_rsp_ready.

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[OFF-1:0] == '0) && ({1'b0, a[ADDR_W-1:OFF]} < DEPTH_W);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  st_idx;
    logic              ld_ok;
    logic              st_ok;
    logic              ld_accept;
    logic              st_write;
    logic              fwd_hit;
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] merged_word;

    // Read stage: one load in flight between the BRAM read and the buffer push.
    logic              p1_valid;
    logic              p1_err;
    logic [DATA_W-1:0] p1_data;

    logic [DATA_W-1:0] buf_data [2];
    logic              buf_err  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_cnt;
    logic [1:0]        occ;
    logic              push;
    logic              pop;

    assign ld_idx    = ld_req_addr[ADDR_W-1:OFF];
    assign st_idx    = st_addr[ADDR_W-1:OFF];
    assign ld_ok     = addr_ok(ld_req_addr);
    assign st_ok     = addr_ok(st_addr);
    assign ld_accept = ld_req_valid && ld_req_ready;
    assign st_write  = st_en && st_ok && (st_strb != '0);
    assign fwd_hit   = st_write && ld_ok && (ld_idx == st_idx);
    assign mem_word  = mem[ld_idx[MEM_AW-1:0]];

    // Write-first merge for a load that meets a store to the same word.
    always_comb begin
        merged_word = mem_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (st_strb[b]) merged_word[8*b +: 8] = st_data[8*b +: 8];
        end
    end

    // Memory contents survive reset; stores are ignored while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && st_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (st_strb[b]) mem[st_idx[MEM_AW-1:0]][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_err   <= 1'b0;
            p1_data  <= '0;
            st_err   <= 1'b0;
        end else begin
            p1_valid <= ld_accept;
            p1_err   <= ld_accept && !ld_ok;
            st_err   <= st_en && !st_ok;
            if (ld_accept) begin
                if (!ld_ok)       p1_data <= '0;
                else if (fwd_hit) p1_data <= merged_word;
                else              p1_data <= mem_word;
            end
        end
    end

    assign push         = p1_valid;
    assign ld_rsp_valid = (buf_cnt != 2'd0);
    assign pop          = ld_rsp_valid && ld_rsp_ready;
    assign ld_rsp_data  = ld_rsp_valid ? buf_data[rd_ptr] : '0;
    assign ld_rsp_err   = ld_rsp_valid ? buf_err[rd_ptr] : 1'b0;
    // occ counts the in-flight read plus buffered entries, so it bounds the buffer.
    assign ld_req_ready = (occ < 2'd2) || pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_err[i]  <= 1'b0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
            occ     <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= p1_data;
                buf_err[wr_ptr]  <= p1_err;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
            case ({ld_accept, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (buf_cnt == 2'd2) && !pop));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stores, partial stores, forwarding,
// back-pressure, address errors and asynchronous reset with buffered responses.
module tb_data_mem_ctrl;

    localparam int DW = 64;
    localparam int DEPTH = 1024;
    localparam int AW = 14;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_req_valid;
    logic          ld_req_ready;
    logic [AW-1:0] ld_req_addr;
    logic          ld_rsp_valid;
    logic          ld_rsp_ready;
    logic [DW-1:0] ld_rsp_data;
    logic          ld_rsp_err;
    logic          st_en;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [SW-1:0] st_strb;
    logic          st_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam logic [DW-1:0] W000 = 64'hA0A0_A0A0_0000_0000;
    localparam logic [DW-1:0] W008 = 64'hA8A8_0000_0000_0008;
    localparam logic [DW-1:0] W010 = 64'h1122_3344_5566_7788;
    localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
        .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_strb(st_strb),
        .st_err(st_err)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        st_en = 1'b1; st_addr = a; st_data = d; st_strb = s;
        tick();
        st_en = 1'b0; st_strb = '0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, output logic acc, output logic early_v,
                           output logic v, output logic [DW-1:0] d, output logic e);
        ld_rsp_ready = 1'b1; ld_req_valid = 1'b1; ld_req_addr = a;
        #1 acc = ld_req_ready;
        tick();
        ld_req_valid = 1'b0;
        early_v = ld_rsp_valid;
        tick();
        v = ld_rsp_valid; d = ld_rsp_data; e = ld_rsp_err;
        tick();
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst_n = 1'b0; ld_req_valid = 1'b0; ld_req_addr = '0; ld_rsp_ready = 1'b1;
        st_en = 1'b0; st_addr = '0; st_data = '0; st_strb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (ld_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", ld_rsp_valid); else pass_cnt++;
        chk_cnt++; if (ld_rsp_data !== '0) $display("FAIL rst_rsp_data got %h exp 0", ld_rsp_data); else pass_cnt++;
        chk_cnt++; if (ld_rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b exp 0", ld_rsp_err); else pass_cnt++;
        chk_cnt++; if (st_err !== 1'b0) $display("FAIL rst_st_err got %b exp 0", st_err); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (ld_req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", ld_req_ready); else pass_cnt++;
        tick();
    endtask

    task automatic test_store_load();
        logic acc, ev, v, e;
        logic [DW-1:0] d;
        do_store(14'h010, W010, 8'hFF);
        do_load(14'h010, acc, ev, v, d, e);
        chk_cnt++; if (acc !== 1'b1) $display("FAIL sl_accept got %b exp 1", acc); else pass_cnt++;
        chk_cnt++; if (ev !== 1'b0) $display("FAIL sl_early_valid got %b exp 0", ev); else pass_cnt++;
        chk_cnt++; if (v !== 1'b1) $display("FAIL sl_valid got %b exp 1", v); else pass_cnt++;
        chk_cnt++; if (d !== W010) $display("FAIL sl_data got %h exp %h", d, W010); else pass_cnt++;
        chk_cnt++; if (e !== 1'b0) $display("FAIL sl_err got %b exp 0", e); else pass_cnt++;
        chk_cnt++; if (ld_rsp_valid !== 1'b0) $display("FAIL sl_popped got %b exp 0", ld_rsp_valid); else pass_cnt++;
    endtask

    task automatic test_partial_store();
        logic acc, ev, v, e;
        logic [DW-1:0] d;
        do_store(14'h018, ONES, 8'hFF);
        do_store(14'h018, 64'h0000_0000_0000_AB00, 8'h02);
        do_load(14'h018, acc, ev, v, d, e);
        chk_cnt++; if (d !== 64'hFFFF_FFFF_FFFF_ABFF) $display("FAIL partial_data got %h exp ffffffffffffabff", d); else pass_cnt++;
        // Zero strobe at a valid address: no write, no error.
        do_store(14'h018, 64'h0, 8'h00);
        chk_cnt++; if (st_err !== 1'b0) $display("FAIL strb0_st_err got %b exp 0", st_err); else pass_cnt++;
        do_load(14'h018, acc, ev, v, d, e);
        chk_cnt++; if (d !== 64'hFFFF_FFFF_FFFF_ABFF) $display("FAIL strb0_data got %h exp ffffffffffffabff", d); else pass_cnt++;
    endtask

    task automatic test_forwarding();
        logic acc, ev, v, e;
        logic [DW-1:0] d;
        do_store(14'h020, 64'h0, 8'hFF);
        st_en = 1'b1; st_addr = 14'h020; st_data = 64'h0000_0000_0000_DEAD; st_strb = 8'h03;
        ld_rsp_ready = 1'b1; ld_req_valid = 1'b1; ld_req_addr = 14'h020;
        tick();
        // A store one cycle after acceptance must not reach the response.
        ld_req_valid = 1'b0;
        st_data = ONES; st_strb = 8'hFF;
        tick();
        st_en = 1'b0; st_strb = '0;
        chk_cnt++; if (ld_rsp_valid !== 1'b1) $display("FAIL fwd_valid got %b exp 1", ld_rsp_valid); else pass_cnt++;
        chk_cnt++; if (ld_rsp_data !== 64'h0000_0000_0000_DEAD) $display("FAIL fwd_data got %h exp 000000000000dead", ld_rsp_data); else pass_cnt++;
        tick();
        do_load(14'h020, acc, ev, v, d, e);
        chk_cnt++; if (d !== ONES) $display("FAIL late_store_data got %h exp %h", d, ONES); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_store(14'h000, W000, 8'hFF);
        do_store(14'h008, W008, 8'hFF);
        // Sustained one load per cycle with the consumer always ready.
        ld_rsp_ready = 1'b1; ld_req_valid = 1'b1; ld_req_addr = 14'h000;
        tick();
        ld_req_addr = 14'h008;
        chk_cnt++; if (ld_req_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ld_req_ready); else pass_cnt++;
        tick();
        ld_req_valid = 1'b0;
        chk_cnt++; if (ld_rsp_data !== W000 || ld_rsp_valid !== 1'b1) $display("FAIL b2b_rsp0 got %h v=%b exp %h", ld_rsp_data, ld_rsp_valid, W000); else pass_cnt++;
        tick();
        chk_cnt++; if (ld_rsp_data !== W008 || ld_rsp_valid !== 1'b1) $display("FAIL b2b_rsp1 got %h v=%b exp %h", ld_rsp_data, ld_rsp_valid, W008); else pass_cnt++;
        tick();
        chk_cnt++; if (ld_rsp_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", ld_rsp_valid); else pass_cnt++;

        // Stalled consumer: two accepted, third held off.
        ld_rsp_ready = 1'b0; ld_req_valid = 1'b1; ld_req_addr = 14'h000;
        tick();
        ld_req_addr = 14'h008;
        tick();
        ld_req_addr = 14'h010;
        #1;
        chk_cnt++; if (ld_req_ready !== 1'b0) $display("FAIL stall_ready got %b exp 0", ld_req_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (ld_rsp_data !== W000) $display("FAIL stall_head got %h exp %h", ld_rsp_data, W000); else pass_cnt++;
        tick();
        chk_cnt++; if (ld_rsp_data !== W000 || ld_rsp_valid !== 1'b1) $display("FAIL stall_hold got %h exp %h", ld_rsp_data, W000); else pass_cnt++;
        chk_cnt++; if (ld_req_ready !== 1'b0) $display("FAIL stall_ready2 got %b exp 0", ld_req_ready); else pass_cnt++;
        ld_rsp_ready = 1'b1;
        #1;
        chk_cnt++; if (ld_req_ready !== 1'b1) $display("FAIL unstall_ready got %b exp 1", ld_req_ready); else pass_cnt++;
        tick();
        ld_req_valid = 1'b0;
        chk_cnt++; if (ld_rsp_data !== W008 || ld_rsp_valid !== 1'b1) $display("FAIL order1 got %h v=%b exp %h", ld_rsp_data, ld_rsp_valid, W008); else pass_cnt++;
        tick();
        chk_cnt++; if (ld_rsp_data !== W010 || ld_rsp_valid !== 1'b1) $display("FAIL order2 got %h v=%b exp %h", ld_rsp_data, ld_rsp_valid, W010); else pass_cnt++;
        tick();
        chk_cnt++; if (ld_rsp_valid !== 1'b0) $display("FAIL no_dup got %b exp 0", ld_rsp_valid); else pass_cnt++;
    endtask

    task automatic test_errors();
        logic acc, ev, v, e;
        logic [DW-1:0] d;
        do_load(14'h00C, acc, ev, v, d, e);
        chk_cnt++; if (v !== 1'b1 || e !== 1'b1 || d !== '0) $display("FAIL misalign_load got v=%b err=%b data=%h exp 1 1 0", v, e, d); else pass_cnt++;
        do_load(14'h2000, acc, ev, v, d, e);
        chk_cnt++; if (v !== 1'b1 || e !== 1'b1 || d !== '0) $display("FAIL range_load got v=%b err=%b data=%h exp 1 1 0", v, e, d); else pass_cnt++;
        do_store(14'h00C, 64'h0, 8'hFF);
        chk_cnt++; if (st_err !== 1'b1) $display("FAIL misalign_st_err got %b exp 1", st_err); else pass_cnt++;
        tick();
        chk_cnt++; if (st_err !== 1'b0) $display("FAIL st_err_width got %b exp 0", st_err); else pass_cnt++;
        do_store(14'h2000, 64'h0, 8'hFF);
        chk_cnt++; if (st_err !== 1'b1) $display("FAIL range_st_err got %b exp 1", st_err); else pass_cnt++;
        do_load(14'h008, acc, ev, v, d, e);
        chk_cnt++; if (d !== W008 || e !== 1'b0) $display("FAIL no_write got %h err=%b exp %h", d, e, W008); else pass_cnt++;
        chk_cnt++; if (st_err !== 1'b0) $display("FAIL st_err_clear got %b exp 0", st_err); else pass_cnt++;
    endtask

    task automatic test_midreset();
        logic acc, ev, v, e;
        logic [DW-1:0] d;
        ld_rsp_ready = 1'b0; ld_req_valid = 1'b1; ld_req_addr = 14'h008;
        tick();
        ld_req_addr = 14'h010;
        tick();
        ld_req_valid = 1'b0;
        tick();
        chk_cnt++; if (ld_rsp_valid !== 1'b1 || dut.occ !== 2'd2) $display("FAIL pre_rst got v=%b occ=%0d exp 1 2", ld_rsp_valid, dut.occ); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (ld_rsp_valid !== 1'b0) $display("FAIL async_rst_valid got %b exp 0", ld_rsp_valid); else pass_cnt++;
        chk_cnt++; if (dut.occ !== 2'd0) $display("FAIL async_rst_occ got %0d exp 0", dut.occ); else pass_cnt++;
        // A store presented during reset must be dropped.
        st_en = 1'b1; st_addr = 14'h000; st_data = 64'h0; st_strb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        st_en = 1'b0; st_strb = '0; ld_rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (ld_req_ready !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", ld_req_ready); else pass_cnt++;
        tick();
        tick();
        chk_cnt++; if (ld_rsp_valid !== 1'b0) $display("FAIL post_rst_discard got %b exp 0", ld_rsp_valid); else pass_cnt++;
        do_load(14'h000, acc, ev, v, d, e);
        chk_cnt++; if (d !== W000) $display("FAIL rst_store_ignored got %h exp %h", d, W000); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_forwarding();
        test_back_to_back();
        test_errors();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
